// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and timing helper for the UART frame parser.
package uart_frame_pkg;

   localparam logic [7:0] SOF = 8'hA5;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      LEN     = 3'd1,
      PAYLOAD = 3'd2,
      CHK     = 3'd3,
      SEND    = 3'd4
   } state_t;

   localparam logic [1:0] ERR_LEN     = 2'd0;
   localparam logic [1:0] ERR_CHK     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   // Inter-byte silence, in clocks, that aborts a partially received frame.
   function automatic int timeout_count(input longint clks_freq, input longint baud_rate,
                                        input longint timeout_bytes);
      return int'((timeout_bytes * longint'(10) * clks_freq) / baud_rate);
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload storage: synchronous write port, combinational read port, no reset.
module uart_frame_buf #(
   parameter int MAX_LEN = 16,
   parameter int IDX_W   = 5
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [7:0]       i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [7:0]       o_rdata
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0] r_mem [MAX_LEN];
   logic       w_unused_idx_msb;

   // Indices never exceed MAX_LEN-1, so the top index bit is not needed for addressing.
   assign w_unused_idx_msb = ^{i_waddr[IDX_W-1:AW], i_raddr[IDX_W-1:AW]};

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr[AW-1:0]] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr[AW-1:0]];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from a UART byte stream and releases
// checksum-verified payloads on a valid/ready byte stream.
module uart_rx_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int CLKS_FREQ     = 50000000,
   parameter int BAUD_RATE     = 9600,
   parameter int MAX_LEN       = 16,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_flag,
   input  logic [7:0] i_rx_byte,
   output logic       o_out_valid,
   output logic [7:0] o_out_data,
   output logic       o_out_last,
   input  logic       i_out_ready,
   output logic       o_frame_ok,
   output logic       o_frame_err,
   output logic [1:0] o_err_code
);
   localparam int IDX_W    = $clog2(MAX_LEN) + 1;
   localparam int TERM_CNT = timeout_count(CLKS_FREQ, BAUD_RATE, TIMEOUT_BYTES);
   localparam int CNT_W    = $clog2(TERM_CNT) + 1;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_len, w_len_nxt;
   logic [7:0]       r_chk, w_chk_nxt;
   logic [IDX_W-1:0] r_wr_idx, w_wr_idx_nxt;
   logic [IDX_W-1:0] r_rd_idx, w_rd_idx_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_frame_ok, w_frame_ok_nxt;
   logic             r_frame_err, w_frame_err_nxt;
   logic [1:0]       r_err_code, w_err_code_nxt;
   logic             w_we;
   logic             w_timeout;
   logic             w_wr_last;
   logic             w_rd_last;
   logic             w_len_bad;
   logic [7:0]       w_rdata;

   assign w_timeout = (r_cnt == CNT_W'(TERM_CNT));
   assign w_wr_last = (9'(r_wr_idx) == ({1'b0, r_len} - 9'd1));
   assign w_rd_last = (9'(r_rd_idx) == ({1'b0, r_len} - 9'd1));
   assign w_len_bad = (i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN));

   uart_frame_buf #(
      .MAX_LEN (MAX_LEN),
      .IDX_W   (IDX_W)
   ) u_buf (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (r_wr_idx),
      .i_wdata (i_rx_byte),
      .i_raddr (r_rd_idx),
      .o_rdata (w_rdata)
   );

   // Next-state, datapath and status decode for the frame FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_len_nxt       = r_len;
      w_chk_nxt       = r_chk;
      w_wr_idx_nxt    = r_wr_idx;
      w_rd_idx_nxt    = r_rd_idx;
      w_cnt_nxt       = {CNT_W{1'b0}};
      w_frame_ok_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      w_err_code_nxt  = r_err_code;
      w_we            = 1'b0;

      case (r_state)
         HUNT: begin
            if (i_rx_flag && (i_rx_byte == SOF)) begin
               w_state_nxt = LEN;
            end else begin
               w_state_nxt = HUNT;
            end
         end
         LEN: begin
            if (i_rx_flag) begin
               if (w_len_bad) begin
                  w_frame_err_nxt = 1'b1;
                  w_err_code_nxt  = ERR_LEN;
                  w_state_nxt     = HUNT;
               end else begin
                  w_len_nxt    = i_rx_byte;
                  w_chk_nxt    = i_rx_byte;
                  w_wr_idx_nxt = {IDX_W{1'b0}};
                  w_state_nxt  = PAYLOAD;
               end
            end else begin
               w_state_nxt = LEN;
            end
         end
         PAYLOAD: begin
            if (i_rx_flag) begin
               w_we         = 1'b1;
               w_chk_nxt    = r_chk ^ i_rx_byte;
               w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
               w_state_nxt  = w_wr_last ? CHK : PAYLOAD;
            end else begin
               w_state_nxt = PAYLOAD;
            end
         end
         CHK: begin
            if (i_rx_flag) begin
               if (i_rx_byte == r_chk) begin
                  w_frame_ok_nxt = 1'b1;
                  w_rd_idx_nxt   = {IDX_W{1'b0}};
                  w_state_nxt    = SEND;
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_err_code_nxt  = ERR_CHK;
                  w_state_nxt     = HUNT;
               end
            end else begin
               w_state_nxt = CHK;
            end
         end
         SEND: begin
            // A byte arriving while draining is dropped; the buffered frame is unaffected.
            if (i_rx_flag) begin
               w_frame_err_nxt = 1'b1;
               w_err_code_nxt  = ERR_OVERRUN;
            end else begin
               w_frame_err_nxt = 1'b0;
            end
            if (i_out_ready) begin
               if (w_rd_last) begin
                  w_state_nxt = HUNT;
               end else begin
                  w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
               end
            end else begin
               w_state_nxt = SEND;
            end
         end
         default: begin
            w_state_nxt = HUNT;
         end
      endcase

      if (((r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK)) && !i_rx_flag) begin
         if (w_timeout) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_TIMEOUT;
            w_state_nxt     = HUNT;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end else begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end
   end

   // State and status registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= HUNT;
         r_len       <= 8'd0;
         r_chk       <= 8'd0;
         r_wr_idx    <= {IDX_W{1'b0}};
         r_rd_idx    <= {IDX_W{1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_code  <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_chk       <= w_chk_nxt;
         r_wr_idx    <= w_wr_idx_nxt;
         r_rd_idx    <= w_rd_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_frame_ok  <= w_frame_ok_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_err_code  <= w_err_code_nxt;
      end
   end

   assign o_out_valid = (r_state == SEND);
   assign o_out_last  = o_out_valid && w_rd_last;
   assign o_out_data  = o_out_valid ? w_rdata : 8'd0;
   assign o_frame_ok  = r_frame_ok;
   assign o_frame_err = r_frame_err;
   assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed and randomized frame tests against a frame-level reference model.
module tb_uart_rx_frame_parser;
   localparam int CLKS_FREQ     = 96000;
   localparam int BAUD_RATE     = 9600;
   localparam int MAX_LEN       = 16;
   localparam int TIMEOUT_BYTES = 4;
   localparam int TC            = TIMEOUT_BYTES * 10 * CLKS_FREQ / BAUD_RATE;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_flag;
   logic [7:0] rx_byte;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   int         checks = 0;
   int         errors = 0;
   int         ok_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] got_data[$];
   logic       got_last[$];
   logic [1:0] exp_code;

   uart_rx_frame_parser #(
      .CLKS_FREQ     (CLKS_FREQ),
      .BAUD_RATE     (BAUD_RATE),
      .MAX_LEN       (MAX_LEN),
      .TIMEOUT_BYTES (TIMEOUT_BYTES)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx_flag   (rx_flag),
      .i_rx_byte   (rx_byte),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .i_out_ready (out_ready),
      .o_frame_ok  (frame_ok),
      .o_frame_err (frame_err),
      .o_err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Sink-side monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
         end
         if (frame_ok) ok_cnt++;
         if (frame_err) err_cnt++;
         if (frame_ok || frame_err) check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_flag = 1'b1;
      rx_byte = b;
      tick(1);
      rx_flag = 1'b0;
      rx_byte = 8'($urandom);
   endtask

   task automatic send_q(input byte_q_t q, input int maxgap);
      foreach (q[i]) begin
         send_byte(q[i]);
         if (i != q.size() - 1) tick($urandom_range(0, maxgap));
      end
   endtask

   function automatic byte_q_t make_frame(input byte_q_t payload, input logic corrupt);
      byte_q_t    f;
      logic [7:0] c;
      c = 8'(payload.size());
      f.push_back(8'hA5);
      f.push_back(8'(payload.size()));
      foreach (payload[i]) begin
         f.push_back(payload[i]);
         c = c ^ payload[i];
      end
      if (corrupt) c = c ^ 8'($urandom_range(1, 255));
      f.push_back(c);
      return f;
   endfunction

   function automatic byte_q_t rand_payload(input int len);
      byte_q_t p;
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   task automatic run_good(input byte_q_t payload, input logic rand_ready);
      int base_ok;
      int base_err;
      int budget;
      base_ok  = ok_cnt;
      base_err = err_cnt;
      got_data.delete();
      got_last.delete();
      send_q(make_frame(payload, 1'b0), 3);
      budget = 1000;
      while ((got_data.size() < payload.size() || out_valid) && budget > 0) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         tick(1);
         budget--;
      end
      out_ready = 1'b1;
      check("good_drain_budget", 32'(budget > 0), 32'd1);
      check("good_len", 32'(got_data.size()), 32'(payload.size()));
      if (got_data.size() == payload.size()) begin
         foreach (payload[i]) begin
            check("good_data", 32'(got_data[i]), 32'(payload[i]));
            check("good_last", 32'(got_last[i]), 32'(i == payload.size() - 1));
         end
      end
      check("good_ok_pulses", 32'(ok_cnt - base_ok), 32'd1);
      check("good_err_pulses", 32'(err_cnt - base_err), 32'd0);
      check("good_err_code_held", 32'(err_code), 32'(exp_code));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int      base_ok;
      int      base_err;
      byte_q_t q;
      rst = 1'b1; rx_flag = 1'b0; rx_byte = 8'd0; out_ready = 1'b1; exp_code = 2'd0;

      // Reset state
      tick(3);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_ok", 32'(frame_ok), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check("rst_code", 32'(err_code), 32'd0);
      rst = 1'b0;
      tick(1);
      check("post_rst_pulses", 32'({frame_ok, frame_err}), 32'd0);

      // Directed good frame with cycle-exact output timing
      q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
      send_q(q, 1);
      tick(1);
      send_byte(8'h03);
      check("g_ok", 32'(frame_ok), 32'd1);
      check("g_v0", 32'(out_valid), 32'd1);
      check("g_d0", 32'(out_data), 32'h11);
      check("g_l0", 32'(out_last), 32'd0);
      tick(1);
      check("g_ok_once", 32'(frame_ok), 32'd0);
      check("g_d1", 32'(out_data), 32'h22);
      check("g_l1", 32'(out_last), 32'd0);
      tick(1);
      check("g_d2", 32'(out_data), 32'h33);
      check("g_l2", 32'(out_last), 32'd1);
      tick(1);
      check("g_v_end", 32'(out_valid), 32'd0);
      check("g_code", 32'(err_code), 32'd0);
      check("g_err_none", 32'(err_cnt), 32'd0);

      // Bad checksum, then a good frame
      got_data.delete();
      send_q('{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00}, 2);
      check("bc_err", 32'(frame_err), 32'd1);
      check("bc_code", 32'(err_code), 32'd1);
      tick(2);
      check("bc_no_out", 32'(got_data.size()), 32'd0);
      exp_code = 2'd1;
      run_good(rand_payload(5), 1'b0);

      // Length errors and a stray byte in HUNT
      send_q('{8'hA5, 8'h00}, 1);
      check("len0_err", 32'(frame_err), 32'd1);
      check("len0_code", 32'(err_code), 32'd0);
      tick(1);
      send_q('{8'hA5, 8'h11}, 1);
      check("len17_err", 32'(frame_err), 32'd1);
      check("len17_code", 32'(err_code), 32'd0);
      exp_code = 2'd0;
      tick(1);
      base_ok = ok_cnt; base_err = err_cnt;
      send_byte(8'h11);
      tick(2);
      check("hunt_quiet_err", 32'(err_cnt - base_err), 32'd0);
      check("hunt_quiet_ok", 32'(ok_cnt - base_ok), 32'd0);

      // Timeout: error on the cycle after TC silent cycles following the last flag
      send_q('{8'hA5, 8'h02, 8'hAA}, 2);
      tick(TC);
      check("to_early", 32'(frame_err), 32'd0);
      tick(1);
      check("to_err", 32'(frame_err), 32'd1);
      check("to_code", 32'(err_code), 32'd2);
      exp_code = 2'd2;
      tick(1);
      // A flag on the terminal cycle keeps the frame alive
      send_q('{8'hA5, 8'h02, 8'hAA}, 2);
      tick(TC);
      send_byte(8'hBB);
      check("to_suppressed", 32'(frame_err), 32'd0);
      send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
      check("to_sup_ok", 32'(frame_ok), 32'd1);
      check("to_sup_d0", 32'(out_data), 32'hAA);
      tick(1);
      check("to_sup_d1", 32'(out_data), 32'hBB);
      check("to_sup_l1", 32'(out_last), 32'd1);
      tick(1);

      // Backpressure and overrun
      got_data.delete();
      out_ready = 1'b0;
      send_q('{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B}, 2);
      check("bp_ok", 32'(frame_ok), 32'd1);
      check("bp_d0", 32'(out_data), 32'h5A);
      tick(3);
      check("bp_hold_v", 32'(out_valid), 32'd1);
      check("bp_hold_d", 32'(out_data), 32'h5A);
      send_byte(8'h77);
      check("ovr_err", 32'(frame_err), 32'd1);
      check("ovr_code", 32'(err_code), 32'd3);
      check("ovr_hold_d", 32'(out_data), 32'h5A);
      out_ready = 1'b1;
      tick(1);
      check("ovr_d1", 32'(out_data), 32'hC3);
      check("ovr_l1", 32'(out_last), 32'd1);
      tick(1);
      check("ovr_v_end", 32'(out_valid), 32'd0);
      check("ovr_got", 32'(got_data.size()), 32'd2);
      exp_code = 2'd3;

      // Reset mid-payload aborts silently
      send_q('{8'hA5, 8'h04, 8'h01, 8'h02}, 1);
      base_err = err_cnt;
      rst = 1'b1;
      tick(1);
      check("mid_rst_outs", 32'({out_valid, out_last, frame_ok, frame_err, err_code}), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      tick(1);
      check("mid_rst_quiet", 32'({frame_ok, frame_err}), 32'd0);
      check("mid_rst_no_pulse", 32'(err_cnt - base_err), 32'd0);
      exp_code = 2'd0;

      // Overrun coinciding with the final transfer drops an SOF byte
      out_ready = 1'b0;
      send_q('{8'hA5, 8'h01, 8'h42, 8'h43}, 1);
      check("ovl_last", 32'(out_last), 32'd1);
      out_ready = 1'b1;
      send_byte(8'hA5);
      check("ovl_err", 32'(frame_err), 32'd1);
      check("ovl_code", 32'(err_code), 32'd3);
      check("ovl_v_end", 32'(out_valid), 32'd0);
      exp_code = 2'd3;
      base_ok = ok_cnt;
      send_q('{8'h01, 8'h42, 8'h43}, 1);
      tick(2);
      check("ovl_sof_lost", 32'(ok_cnt - base_ok), 32'd0);

      // Noise before SOF
      send_q('{8'h00, 8'hFF}, 2);
      run_good(rand_payload(MAX_LEN), 1'b1);

      // Randomized frames against the frame-level model
      for (int f = 0; f < 24; f++) begin
         int kind;
         int len;
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, MAX_LEN);
         if (kind <= 1) begin
            run_good(rand_payload(len), 1'b1);
         end else begin
            base_ok = ok_cnt; base_err = err_cnt;
            got_data.delete();
            if (kind == 2) begin
               send_q(make_frame(rand_payload(len), 1'b1), 3);
               exp_code = 2'd1;
            end else begin
               send_q('{8'hA5, ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255))}, 3);
               exp_code = 2'd0;
            end
            tick(3);
            check("rnd_err_pulse", 32'(err_cnt - base_err), 32'd1);
            check("rnd_no_ok", 32'(ok_cnt - base_ok), 32'd0);
            check("rnd_err_code", 32'(err_code), 32'(exp_code));
            check("rnd_no_out", 32'(got_data.size()), 32'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
Consumes the byte stream produced by the UART receiver: a one-cycle rx_flag pulse with rx_byte. Assembles fixed-format frames: SOF 0xA5, LEN, LEN payload bytes, then CHK, where CHK is the XOR of LEN and all payload bytes. Buffers the payload until the checksum passes, then releases it on a valid/ready byte stream with a last marker. Malformed frames, stalled frames and overruns are reported with an error pulse and a held error code.

Parameters:
CLKS_FREQ, 50000000, input clock frequency in Hz
BAUD_RATE, 9600, UART bit rate; byte time is 10*CLKS_FREQ/BAUD_RATE clocks
MAX_LEN, 16, maximum payload length in bytes (1..255)
TIMEOUT_BYTES, 4, inter-byte gap in byte times that aborts a partial frame

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_flag  in  1  one-cycle byte-valid pulse from the UART receiver
rx_byte  in  8  received byte, valid while rx_flag=1
out_valid  out  1  payload byte available
out_data  out  8  payload byte
out_last  out  1  marks the final payload byte of the frame
out_ready  in  1  sink accepts the byte when out_valid&out_ready
frame_ok  out  1  one-cycle pulse: checksum passed
frame_err  out  1  one-cycle pulse: frame dropped
err_code  out  2  cause of the last error, held until the next error: 0=LEN, 1=CHK, 2=TIMEOUT, 3=OVERRUN

Behaviour:
- Reset: state HUNT; out_valid, out_last, frame_ok, frame_err and err_code are all 0; indices, checksum and timeout counter are 0. Reset during any state aborts that state immediately, with no error pulse.
- HUNT: on rx_flag with rx_byte==0xA5, go to LEN. All other bytes are ignored silently.
- LEN:
  - rx_byte==0 or rx_byte>MAX_LEN: frame_err, err_code=0, go to HUNT.
  - Otherwise: len<=rx_byte, chk<=rx_byte, wr_idx<=0, go to PAYLOAD.
- PAYLOAD: on each rx_flag, buf[wr_idx]<=rx_byte, chk<=chk^rx_byte, wr_idx++. The flag that writes index len-1 moves the FSM to CHK.
- CHK:
  - rx_byte==chk: pulse frame_ok, rd_idx<=0, go to SEND.
  - Otherwise: frame_err, err_code=1, go to HUNT.
  - frame_ok and the first out_valid both appear in the cycle after the CHK flag.
- SEND:
  - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==len-1).
  - The transfer on valid&ready advances rd_idx.
  - The last transfer returns the FSM to HUNT; out_valid is 0 in the next cycle.
  - out_valid and out_data are stable while out_ready=0.
- Overrun: rx_flag in SEND drops the byte and raises frame_err with err_code=3. The buffered frame continues undisturbed. This also applies when the flag coincides with the last transfer; the FSM still goes to HUNT and the byte is lost even if it is 0xA5.
- Timeout:
  - The counter runs in LEN, PAYLOAD and CHK and clears on every rx_flag.
  - When it reaches TIMEOUT_BYTES*10*CLKS_FREQ/BAUD_RATE: frame_err, err_code=2, go to HUNT.
  - If rx_flag and the terminal count occur in the same cycle, rx_flag wins.
  - The counter is held at 0 in HUNT and SEND and is sized with $clog2 of the terminal count, plus 1 bit.
- Width rules: wr_idx and rd_idx are $clog2(MAX_LEN)+1 bits; chk is 8 bits and wraps as XOR (no carry).
- frame_ok and frame_err are never asserted in the same cycle. Neither is asserted in the cycle after reset deasserts.

Decomposition:
- Package uart_frame_pkg holds:
  - SOF constant 0xA5
  - the 3-bit state encodings HUNT/LEN/PAYLOAD/CHK/SEND
  - the error-code constants ERR_LEN/ERR_CHK/ERR_TIMEOUT/ERR_OVERRUN
  - a function computing the timeout terminal count from CLKS_FREQ, BAUD_RATE and TIMEOUT_BYTES
- One sub-module, uart_frame_buf: MAX_LEN x 8 storage with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata). No reset on the storage.

Test Plan:
- Good frame: rx bytes A5 03 11 22 33 03, out_ready=1 → frame_ok pulse once; out_data 11, 22, 33 on consecutive cycles; out_last only with 33; err_code remains 0.
- Bad checksum: A5 02 AA 55 00 (correct CHK is FD) → frame_err with err_code=1; out_valid never asserts; a following good frame is delivered normally.
- Length errors:
  - A5 00 → frame_err with err_code=0.
  - A5 11 (17 > MAX_LEN) → frame_err with err_code=0.
  - 0x11 arriving in HUNT alone → no response.
- Timeout: A5 02 AA, then silence → frame_err with err_code=2 exactly at the terminal count after the AA flag. A flag injected on the terminal cycle suppresses the error.
- Backpressure and overrun: good frame A5 02 5A C3 9B with out_ready=0, then an rx byte 77 → frame_err with err_code=3; out_data is held at 5A. Raising out_ready then delivers 5A, C3(last), and the FSM returns to HUNT.
- Reset and noise:
  - Bytes 00 FF before A5 are ignored.
  - rst asserted mid-PAYLOAD → all outputs 0, no error pulse; the next full good frame is parsed correctly.
